// File: rtl/fetch_if.sv
// Instruction-fetch bus bundle: memory request/response plus the
// decode-side instruction handshake and next-PC controls.
// Shared width and pc_src encoding macros are defined here and guarded
// so every file of the bundle can repeat them safely.

`ifndef W_CPU
`define W_CPU 32
`endif
`ifndef W_PC_SRC
`define W_PC_SRC 2
`endif
`ifndef W_JADDR
`define W_JADDR 26
`endif
`ifndef W_IMM
`define W_IMM 16
`endif
`ifndef PC_SRC_NEXT
`define PC_SRC_NEXT 2'd0
`endif
`ifndef PC_SRC_JUMP
`define PC_SRC_JUMP 2'd1
`endif
`ifndef PC_SRC_BRCH
`define PC_SRC_BRCH 2'd2
`endif
`ifndef PC_SRC_REGF
`define PC_SRC_REGF 2'd3
`endif

interface fetch_if;
  logic                 imem_req;
  logic [`W_CPU-1:0]    imem_addr;
  logic                 imem_ack;
  logic [`W_CPU-1:0]    imem_rdata;
  logic [`W_CPU-1:0]    inst;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [`W_CPU-1:0]    pc_out;
  logic [`W_PC_SRC-1:0] pc_src;
  logic [`W_JADDR-1:0]  jump_addr;
  logic [`W_IMM-1:0]    imm;
  logic                 br_taken;
  logic [`W_CPU-1:0]    reg_target;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, inst, inst_valid, pc_out,
    input  imem_ack, imem_rdata, inst_ready, pc_src, jump_addr, imm,
           br_taken, reg_target
  );

  // Memory/decode environment side
  modport slave (
    input  imem_req, imem_addr, inst, inst_valid, pc_out,
    output imem_ack, imem_rdata, inst_ready, pc_src, jump_addr, imm,
           br_taken, reg_target
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: requests the word at PC, holds it for decode
// until accepted, then computes the next PC from the decode controls.
// Optional feature macro: FETCH_PREFETCH_EN -- while an instruction is
// held, prefetch the sequential word into a one-entry buffer. Without the
// macro no request is issued while an instruction is held.

`ifndef W_CPU
`define W_CPU 32
`endif
`ifndef PC_SRC_NEXT
`define PC_SRC_NEXT 2'd0
`endif
`ifndef PC_SRC_JUMP
`define PC_SRC_JUMP 2'd1
`endif
`ifndef PC_SRC_BRCH
`define PC_SRC_BRCH 2'd2
`endif
`ifndef PC_SRC_REGF
`define PC_SRC_REGF 2'd3
`endif

module fetch #(
  parameter logic [`W_CPU-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);

  // S_DRAIN waits out an abandoned prefetch; unreachable without prefetch.
  typedef enum logic [1:0] {
    S_FETCH,
    S_VALID,
    S_DRAIN
  } state_t;

  state_t            state, state_next;
  logic [`W_CPU-1:0] pc, pc_next;
  logic [`W_CPU-1:0] inst_r, inst_next;
  logic [`W_CPU-1:0] pc_out_r, pc_out_next;
  logic              valid_r, valid_next;
  logic              req;
  logic [`W_CPU-1:0] addr;
  logic [`W_CPU-1:0] p4;
  logic [`W_CPU-1:0] br_off;
  logic [`W_CPU-1:0] target;
  logic              accept;
`ifdef FETCH_PREFETCH_EN
  logic              pf_full, pf_full_next;
  logic [`W_CPU-1:0] pf_data, pf_data_next;
  logic [`W_CPU-1:0] drain_addr, drain_next;
  logic              ack_now;
`endif

  // Next-PC candidate from the decode controls, relative to the held instruction
  always_comb begin
    p4     = pc_out_r + 32'd4;
    br_off = {{14{bus.imm[15]}}, bus.imm, 2'b00};
    accept = valid_r & bus.inst_ready;
    case (bus.pc_src)
      `PC_SRC_NEXT: target = p4;
      `PC_SRC_JUMP: target = {p4[31:28], bus.jump_addr, 2'b00};
      `PC_SRC_BRCH: target = bus.br_taken ? p4 + br_off : p4;
      `PC_SRC_REGF: target = bus.reg_target & ~32'h3;
      default:      target = p4;
    endcase
  end

  // Next-state and output logic for the request/hold handshake
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    inst_next   = inst_r;
    pc_out_next = pc_out_r;
    valid_next  = valid_r;
    req         = 1'b0;
    addr        = pc;
`ifdef FETCH_PREFETCH_EN
    pf_full_next = pf_full;
    pf_data_next = pf_data;
    drain_next   = drain_addr;
    ack_now      = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        req = 1'b1;
        if (bus.imem_ack) begin
          inst_next   = bus.imem_rdata;
          pc_out_next = pc;
          valid_next  = 1'b1;
          state_next  = S_VALID;
        end
      end
      S_VALID: begin
`ifdef FETCH_PREFETCH_EN
        req     = ~pf_full;
        addr    = p4;
        ack_now = req & bus.imem_ack;
        if (ack_now) begin
          pf_full_next = 1'b1;
          pf_data_next = bus.imem_rdata;
        end
`endif
        if (accept) begin
          valid_next = 1'b0;
          pc_next    = target;
          state_next = S_FETCH;
`ifdef FETCH_PREFETCH_EN
          pf_full_next = 1'b0;
          if (target == p4) begin
            if (pf_full | ack_now) begin
              inst_next   = pf_full ? pf_data : bus.imem_rdata;
              pc_out_next = p4;
              valid_next  = 1'b1;
              state_next  = S_VALID;
            end
          end else if (req & ~bus.imem_ack) begin
            drain_next = p4;
            state_next = S_DRAIN;
          end
`endif
        end
      end
`ifdef FETCH_PREFETCH_EN
      S_DRAIN: begin
        req  = 1'b1;
        addr = drain_addr;
        if (bus.imem_ack) state_next = S_FETCH;
      end
`endif
      default: state_next = S_FETCH;
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      inst_r   <= '0;
      pc_out_r <= '0;
      valid_r  <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      pf_full    <= 1'b0;
      pf_data    <= '0;
      drain_addr <= '0;
`endif
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      inst_r   <= inst_next;
      pc_out_r <= pc_out_next;
      valid_r  <= valid_next;
`ifdef FETCH_PREFETCH_EN
      pf_full    <= pf_full_next;
      pf_data    <= pf_data_next;
      drain_addr <= drain_next;
`endif
    end
  end

  assign bus.imem_req   = req & ~rst;
  assign bus.imem_addr  = addr;
  assign bus.inst       = inst_r;
  assign bus.inst_valid = valid_r;
  assign bus.pc_out     = pc_out_r;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch stage (default build, no prefetch).
// A reference next-PC model computed from plain address arithmetic tracks
// the expected PC; memory and decode behaviour are randomized.

`ifndef PC_SRC_NEXT
`define PC_SRC_NEXT 2'd0
`endif
`ifndef PC_SRC_JUMP
`define PC_SRC_JUMP 2'd1
`endif
`ifndef PC_SRC_BRCH
`define PC_SRC_BRCH 2'd2
`endif
`ifndef PC_SRC_REGF
`define PC_SRC_REGF 2'd3
`endif

module tb_fetch;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int passes = 0;
  logic [31:0] model_pc;

  fetch_if bus();

  fetch #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference next-PC computation from the architectural rules
  function automatic logic [31:0] calc_next(input logic [31:0] cur, input logic [1:0] src,
                                            input logic [25:0] j, input logic [15:0] im,
                                            input logic bt, input logic [31:0] rt);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(im)) * 4;
    case (src)
      `PC_SRC_JUMP: return (seq & 32'hF000_0000) | (32'(j) << 2);
      `PC_SRC_BRCH: return bt ? seq + 32'(off) : seq;
      `PC_SRC_REGF: return rt - (rt % 32'd4);
      default:      return seq;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.inst_ready = 1'b0;
    bus.pc_src     = `PC_SRC_NEXT;
    bus.jump_addr  = '0;
    bus.imm        = '0;
    bus.br_taken   = 1'b0;
    bus.reg_target = '0;
  endtask

  task automatic scramble_decode();
    bus.pc_src     = 2'($urandom_range(0, 3));
    bus.jump_addr  = 26'($urandom);
    bus.imm        = 16'($urandom);
    bus.br_taken   = 1'($urandom_range(0, 1));
    bus.reg_target = $urandom;
  endtask

  // One instruction: wait `delay` request cycles, ack `word`, hold for
  // `hold` cycles, then accept with the given controls and check the new PC.
  // Entered and left at a falling edge with a request outstanding.
  task automatic fetch_accept(input logic [31:0] word, input int delay, input int hold,
                              input logic [1:0] src, input logic [25:0] j,
                              input logic [15:0] im, input logic bt,
                              input logic [31:0] rt, input string tag);
    logic [31:0] this_pc;
    this_pc = model_pc;
    for (int i = 0; i < delay; i++) begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      scramble_decode();
      @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== this_pc || bus.inst_valid !== 1'b0)
        $display("[TB] FAIL %s req_hold: req=%b addr=%h valid=%b, expected req=1 addr=%h valid=0",
                 tag, bus.imem_req, bus.imem_addr, bus.inst_valid, this_pc);
      else passes++;
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.inst_valid !== 1'b1 || bus.inst !== word || bus.pc_out !== this_pc)
      $display("[TB] FAIL %s load: valid=%b inst=%h pc_out=%h, expected valid=1 inst=%h pc_out=%h",
               tag, bus.inst_valid, bus.inst, bus.pc_out, word, this_pc);
    else passes++;
    for (int k = 0; k < hold; k++) begin
      bus.inst_ready = 1'b0;
      bus.imem_ack   = 1'($urandom_range(0, 1));
      bus.imem_rdata = $urandom;
      scramble_decode();
      @(negedge clk);
      checks++;
      if (bus.inst_valid !== 1'b1 || bus.inst !== word || bus.pc_out !== this_pc ||
          bus.imem_req !== 1'b0)
        $display("[TB] FAIL %s stall: valid=%b inst=%h pc_out=%h req=%b, expected valid=1 inst=%h pc_out=%h req=0",
                 tag, bus.inst_valid, bus.inst, bus.pc_out, bus.imem_req, word, this_pc);
      else passes++;
    end
    bus.imem_ack   = 1'b0;
    bus.inst_ready = 1'b1;
    bus.pc_src     = src;
    bus.jump_addr  = j;
    bus.imm        = im;
    bus.br_taken   = bt;
    bus.reg_target = rt;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    scramble_decode();
    model_pc = calc_next(this_pc, src, j, im, bt, rt);
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== model_pc)
      $display("[TB] FAIL %s next_pc: valid=%b req=%b addr=%h, expected valid=0 req=1 addr=%h",
               tag, bus.inst_valid, bus.imem_req, bus.imem_addr, model_pc);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b0 || bus.inst !== 32'h0 || bus.pc_out !== 32'h0 ||
        bus.inst_valid !== 1'b0)
      $display("[TB] FAIL reset_state: req=%b inst=%h pc_out=%h valid=%b, expected all zero",
               bus.imem_req, bus.inst, bus.pc_out, bus.inst_valid);
    else passes++;
    rst = 1'b0;
    model_pc = RESET_PC;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC)
      $display("[TB] FAIL reset_release: req=%b addr=%h, expected req=1 addr=%h",
               bus.imem_req, bus.imem_addr, RESET_PC);
    else passes++;
    @(negedge clk);
  endtask

  task automatic check_addr(input logic [31:0] want, input string tag);
    checks++;
    if (bus.imem_addr !== want)
      $display("[TB] FAIL %s addr: got %h, expected %h", tag, bus.imem_addr, want);
    else passes++;
  endtask

  task automatic test_directed();
    fetch_accept(32'h2008_0005, 1, 0, `PC_SRC_NEXT, 26'h0, 16'h0, 1'b0, 32'h0, "first");
    check_addr(32'h0040_0004, "first");
    fetch_accept($urandom, 0, 0, `PC_SRC_NEXT, 26'h0, 16'h0, 1'b0, 32'h0, "seq");
    fetch_accept($urandom, 1, 1, `PC_SRC_JUMP, 26'h010_0003, 16'h0, 1'b0, 32'h0, "jump");
    check_addr(32'h0040_000C, "jump");
    fetch_accept($urandom, 0, 0, `PC_SRC_NEXT, 26'h0, 16'h0, 1'b0, 32'h0, "seq2");
    fetch_accept($urandom, 2, 0, `PC_SRC_BRCH, 26'h0, 16'hFFFE, 1'b1, 32'h0, "br_taken");
    check_addr(32'h0040_000C, "br_taken");
    fetch_accept($urandom, 0, 0, `PC_SRC_NEXT, 26'h0, 16'h0, 1'b0, 32'h0, "seq3");
    fetch_accept($urandom, 0, 2, `PC_SRC_BRCH, 26'h0, 16'hFFFE, 1'b0, 32'h0, "br_not");
    check_addr(32'h0040_0014, "br_not");
    fetch_accept($urandom, 1, 0, `PC_SRC_REGF, 26'h0, 16'h0, 1'b0, 32'h0040_0023, "regf");
    check_addr(32'h0040_0020, "regf");
  endtask

  task automatic test_stall();
    fetch_accept($urandom, 0, 5, `PC_SRC_NEXT, 26'h0, 16'h0, 1'b0, 32'h0, "stall5");
    check_addr(32'h0040_0024, "stall5");
  endtask

  task automatic test_wrap();
    fetch_accept($urandom, 0, 0, `PC_SRC_REGF, 26'h0, 16'h0, 1'b0, 32'hFFFF_FFFF, "to_top");
    check_addr(32'hFFFF_FFFC, "to_top");
    fetch_accept($urandom, 0, 0, `PC_SRC_NEXT, 26'h0, 16'h0, 1'b0, 32'h0, "wrap");
    check_addr(32'h0000_0000, "wrap");
    fetch_accept($urandom, 0, 0, `PC_SRC_BRCH, 26'h0, 16'hFFFE, 1'b1, 32'h0, "br_under");
    check_addr(32'hFFFF_FFFC, "br_under");
    fetch_accept($urandom, 0, 0, `PC_SRC_JUMP, 26'h3FF_FFFF, 16'h0, 1'b0, 32'h0, "jump_wrap");
    check_addr(32'h0FFF_FFFC, "jump_wrap");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      fetch_accept($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   2'($urandom_range(0, 3)), 26'($urandom), 16'($urandom),
                   1'($urandom_range(0, 1)), $urandom, "random");
    end
  endtask

  task automatic test_reset_mid_request();
    logic [31:0] w;
    w = $urandom | 32'h1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = w;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.inst !== 32'h0 || bus.pc_out !== 32'h0 || bus.inst_valid !== 1'b0 ||
        bus.imem_req !== 1'b0)
      $display("[TB] FAIL async_reset_valid: inst=%h pc_out=%h valid=%b req=%b, expected all zero",
               bus.inst, bus.pc_out, bus.inst_valid, bus.imem_req);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0)
      $display("[TB] FAIL async_reset_req: req=%b, expected 0", bus.imem_req);
    else passes++;
    @(negedge clk);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    rst = 1'b0;
    model_pc = RESET_PC;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC || bus.inst_valid !== 1'b0 ||
        bus.inst !== 32'h0)
      $display("[TB] FAIL late_ack: req=%b addr=%h valid=%b inst=%h, expected req=1 addr=%h valid=0 inst=0",
               bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst, RESET_PC);
    else passes++;
    fetch_accept(32'h1357_2468, 0, 1, `PC_SRC_NEXT, 26'h0, 16'h0, 1'b0, 32'h0, "after_reset");
  endtask

  // Sequenced scenarios followed by the summary line
  initial begin
    rst = 1'b1;
    idle_inputs();
    model_pc = RESET_PC;
    test_reset();
    test_directed();
    test_stall();
    test_wrap();
    test_random();
    test_reset_mid_request();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, first instruction address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  instruction memory read request.
REQ-005 imem_addr  output  `W_CPU  byte address of the request; equals current PC.
REQ-006 imem_ack  input  1  memory response strobe; imem_rdata valid in this cycle.
REQ-007 imem_rdata  input  `W_CPU  instruction word returned by memory.
REQ-008 inst  output  `W_CPU  instruction presented to decode.
REQ-009 inst_valid  output  1  inst holds a fetched instruction.
REQ-010 inst_ready  input  1  decode/execute consumes inst this cycle.
REQ-011 pc_out  output  `W_CPU  address of the instruction on inst.
REQ-012 pc_src  input  `W_PC_SRC  next-PC select from decode: PC_SRC_NEXT, PC_SRC_JUMP, PC_SRC_BRCH, PC_SRC_REGF.
REQ-013 jump_addr  input  `W_JADDR  jump field from decode.
REQ-014 imm  input  `W_IMM  branch offset field from decode.
REQ-015 br_taken  input  1  branch condition result.
REQ-016 reg_target  input  `W_CPU  register jump target.

Function
REQ-017 The block SHALL implement states FETCH (request outstanding) and VALID (instruction held for decode).
REQ-018 In FETCH, imem_req=1 and imem_addr=PC, both held stable until imem_ack; on imem_ack, inst<=imem_rdata, pc_out<=PC, inst_valid<=1, state->VALID.
REQ-019 imem_ack while imem_req=0 SHALL be ignored.
REQ-020 In VALID, inst and pc_out SHALL remain stable while inst_ready=0; imem_req=0 (prefetch disabled).
REQ-021 Accept = inst_valid & inst_ready; pc_src, jump_addr, imm, br_taken, reg_target are sampled only in the accept cycle.
REQ-022 On accept, PC<=next PC with P4=pc_out+4: NEXT -> P4; JUMP -> {P4[31:28], jump_addr, 2'b00}; BRCH -> br_taken ? P4+(sign-extended imm<<2) : P4; REGF -> {reg_target[31:2],2'b00}; unknown encodings -> P4.
REQ-023 On accept, inst_valid<=0 and state->FETCH; imem_req asserts the following cycle (minimum 2 cycles per instruction).
REQ-024 Address arithmetic SHALL be modulo 2^32 (wrap at 32'hFFFF_FFFC -> 0).

Reset
REQ-025 rst asserted, at any time including mid-request: PC=RESET_PC, state=FETCH, imem_req=0 during reset, inst=0, pc_out=0, inst_valid=0.
REQ-026 imem_req SHALL assert in the first cycle after rst deasserts; an ack for a request interrupted by reset SHALL be discarded.

Configuration
REQ-027 FETCH_PREFETCH_EN defined: in VALID the block SHALL issue a request for pc_out+4 into a one-entry buffer; on accept with next PC = pc_out+4, the buffered (or still-outstanding) word is used with no refetch; on accept with any other next PC, the buffered word is dropped, an outstanding request is allowed to complete and its ack discarded, then the new PC is requested.
REQ-028 FETCH_PREFETCH_EN undefined: no request is issued while in VALID; behaviour exactly as REQ-017..REQ-024.

Verification
REQ-029 Release rst, ack 32'h2008_0005 on 2nd request cycle -> inst=32'h2008_0005, pc_out=32'h0040_0000, inst_valid=1 next cycle; inst_ready=1, pc_src=NEXT -> imem_addr=32'h0040_0004.
REQ-030 pc_out=32'h0040_0008, pc_src=JUMP, jump_addr=26'h010_0003 -> imem_addr=32'h0040_000C.
REQ-031 pc_out=32'h0040_0010, pc_src=BRCH, imm=16'hFFFE, br_taken=1 -> 32'h0040_000C; br_taken=0 -> 32'h0040_0014.
REQ-032 pc_src=REGF, reg_target=32'h0040_0023 -> imem_addr=32'h0040_0020.
REQ-033 inst_ready=0 for 5 cycles in VALID -> inst, pc_out stable, imem_req=0 (macro off), no PC change.
REQ-034 rst pulsed while imem_req=1, late ack 32'hDEAD_BEEF -> discarded, next request at 32'h0040_0000; with FETCH_PREFETCH_EN, JUMP accept during outstanding prefetch -> stale ack dropped, next inst from jump target.
